pwm_core: RTL

//  PWM generation core downstream of the AXI4-Lite register slave (4 x 32-bit regs).

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_deadband.sv | 52 +++++
 rtl/pwm_core.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and state type for the PWM core and its dead-band helper.
package pwm_pkg;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_POL_BIT  = 1;
  localparam int STAT_RUN_BIT  = 0;
  localparam int STAT_PEND_BIT = 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} pwm_state_t;

endpackage

// File: rtl/pwm_deadband.sv
// Splits the raw PWM level into an active-high p/n pair, holding back each rising
// output until the raw level has been stable for more than deadtime cycles.
module pwm_deadband #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            active,
  input  logic            raw,
  input  logic [DT_W-1:0] deadtime,
  output logic            p,
  output logic            n
);

  localparam logic [DT_W:0] LEN_ONE = (DT_W+1)'(1);

  logic [DT_W:0] len;
  logic [DT_W:0] len_next;
  logic          raw_prev;
  logic          settled;

  // len is the age of the current raw phase including this cycle; zero means "fresh start".
  always_comb begin
    len_next = len;
    if (len == '0 || raw != raw_prev)
      len_next = LEN_ONE;
    else if (len != '1)
      len_next = len + LEN_ONE;
  end

  assign settled = (len_next > {1'b0, deadtime});

  always_ff @(posedge clk) begin
    if (reset) begin
      len      <= '0;
      raw_prev <= 1'b0;
      p        <= 1'b0;
      n        <= 1'b0;
    end else if (!active) begin
      len      <= '0;
      raw_prev <= raw;
      p        <= 1'b0;
      n        <= 1'b0;
    end else begin
      len      <= len_next;
      raw_prev <= raw;
      p        <= raw & settled;
      n        <= ~raw & settled;
    end
  end

endmodule

// File: rtl/pwm_core.sv
// Double-buffered PWM generator with polarity control and status read-back.
// Define PWM_DEADTIME_EN to insert the dead band between pwm_o and pwm_n_o.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int DT_W  = 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [31:0]      ctrl_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic [DT_W-1:0]  deadtime_i,
  input  logic             upd_i,
  output logic             pwm_o,
  output logic             pwm_n_o,
  output logic             cycle_end_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [31:0]      status_o
);

  pwm_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] duty_sh;
  logic             pending;
  logic             pol;
  logic             en;
  logic             wrap;
  logic             raw;
  logic             active;
  logic             p;
  logic             n;

  assign en     = ctrl_i[CTRL_EN_BIT];
  assign wrap   = (cnt == period_sh);
  assign raw    = (cnt < duty_sh);
  assign active = (state == RUN) && en;

`ifdef PWM_DEADTIME_EN
  logic [DT_W-1:0] deadtime_sh;
  logic            unused_ctrl;
  assign unused_ctrl = ^ctrl_i[31:2];
`else
  logic            unused_ctrl;
  assign unused_ctrl = ^{ctrl_i[31:2], deadtime_i};
`endif

  // Shadows follow the inputs while idle; while running they only change at a wrap.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      cnt         <= '0;
      period_sh   <= '0;
      duty_sh     <= '0;
      pending     <= 1'b0;
`ifdef PWM_DEADTIME_EN
      deadtime_sh <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          period_sh   <= period_i;
          duty_sh     <= duty_i;
`ifdef PWM_DEADTIME_EN
          deadtime_sh <= deadtime_i;
`endif
          pending     <= 1'b0;
          cnt         <= '0;
          if (en)
            state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (wrap) begin
            cnt     <= '0;
            pending <= 1'b0;
            if (pending || upd_i) begin
              period_sh   <= period_i;
              duty_sh     <= duty_i;
`ifdef PWM_DEADTIME_EN
              deadtime_sh <= deadtime_i;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (upd_i)
              pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Polarity is registered so it lines up with the registered p/n levels.
  always_ff @(posedge ACLK) begin
    if (ARESET)
      pol <= 1'b0;
    else
      pol <= ctrl_i[CTRL_POL_BIT];
  end

`ifdef PWM_DEADTIME_EN
  pwm_deadband #(.DT_W(DT_W)) u_deadband (
    .clk      (ACLK),
    .reset    (ARESET),
    .active   (active),
    .raw      (raw),
    .deadtime (deadtime_sh),
    .p        (p),
    .n        (n)
  );
`else
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      p <= 1'b0;
      n <= 1'b0;
    end else begin
      p <= active & raw;
      n <= active & ~raw;
    end
  end
`endif

  assign pwm_o       = p ^ pol;
  assign pwm_n_o     = n ^ pol;
  assign cycle_end_o = (state == RUN) && wrap;
  assign cnt_o       = cnt;

  always_comb begin
    status_o                = '0;
    status_o[STAT_RUN_BIT]  = (state == RUN);
    status_o[STAT_PEND_BIT] = pending;
  end

endmodule
